// File: rtl/weight_buffer_writer_pkg.sv
// Shared definitions for the weight buffer writer/reader pair: FSM states,
// shape bus field layout and the channel-chunk shift.
package weight_buffer_writer_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WRITE = 2'd1,
    WB_DONE  = 2'd2
  } wb_state_e;

  localparam int unsigned SHAPE_FIELD_W = 16;
  localparam int unsigned SHAPE_C_LSB   = 0;
  localparam int unsigned SHAPE_H_LSB   = 16;
  localparam int unsigned SHAPE_W_LSB   = 32;
  localparam int unsigned CHUNK_SHIFT   = 6;

  function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] b);
    return (a + b - 32'd1) / b;
  endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// Column offset / bank index / bank base counters for the weight buffer writer.
// Addresses are built purely by incrementing; no per-word multiply.
module weight_addr_gen #(
  parameter int unsigned N_BUF_X    = 5,
  parameter int unsigned B_BUF_ADDR = 9,
  parameter int unsigned X_W        = 16,
  parameter int unsigned RX_W       = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  adv,
  input  logic [B_BUF_ADDR:0]   col_len,
  output logic [B_BUF_ADDR-1:0] addr,
  output logic [RX_W-1:0]       rx,
  output logic [X_W-1:0]        x_idx,
  output logic                  col_end
);

  localparam int unsigned AW1 = B_BUF_ADDR + 1;

  logic [B_BUF_ADDR-1:0] offset;
  logic [B_BUF_ADDR-1:0] base;
  logic [AW1-1:0]        col_last;

  assign col_last = col_len - AW1'(1);
  assign col_end  = ({1'b0, offset} == col_last);
  assign addr     = base + offset;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      offset <= '0;
      base   <= '0;
      rx     <= '0;
      x_idx  <= '0;
    end else if (adv) begin
      if (col_end) begin
        offset <= '0;
        x_idx  <= x_idx + X_W'(1);
        // Base only moves once every bank has received a column.
        if (rx == RX_W'(N_BUF_X - 1)) begin
          rx   <= '0;
          base <= base + col_len[B_BUF_ADDR-1:0];
        end else begin
          rx <= rx + RX_W'(1);
        end
      end else begin
        offset <= offset + B_BUF_ADDR'(1);
      end
    end
  end

endmodule

// File: rtl/weight_buffer_writer.sv
// Streams a weight tensor into N_BUF_X x-interleaved buffer banks.
// Shape checks happen once at start; per-word addressing comes from weight_addr_gen.
module weight_buffer_writer
  import weight_buffer_writer_pkg::*;
#(
  parameter int unsigned N_BUF_X    = 5,
  parameter int unsigned B_BUF_ADDR = 9,
  parameter int unsigned B_SHAPE    = 48,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [B_SHAPE-1:0]             wei_shape,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_tdata,
  input  logic                           s_tvalid,
  input  logic                           s_tlast,
  output logic                           s_tready,
  output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
  output logic [DATA_WIDTH-1:0]          wrdata,
  output logic [N_BUF_X-1:0]             wren,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned RX_W = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam int unsigned AW1  = B_BUF_ADDR + 1;

  wb_state_e state, state_nxt;

  logic [SHAPE_FIELD_W-1:0] shp_c, shp_h, shp_w, n_wrap, w_q, x_idx;
  logic [31:0]              col_len_full, n_cols;
  logic [63:0]              total_words;
  logic                     shape_zero, shape_ovf, start_acc, hs, last_word, col_end;
  logic [AW1-1:0]           col_len_q;
  logic [B_BUF_ADDR-1:0]    addr;
  logic [RX_W-1:0]          rx;

  assign shp_c = wei_shape[SHAPE_C_LSB +: SHAPE_FIELD_W];
  assign shp_h = wei_shape[SHAPE_H_LSB +: SHAPE_FIELD_W];
  assign shp_w = wei_shape[SHAPE_W_LSB +: SHAPE_FIELD_W];

  // Capacity check uses the live shape bus so the start decision needs no extra cycle.
  assign n_wrap       = shp_c >> CHUNK_SHIFT;
  assign col_len_full = 32'(shp_h) * 32'(n_wrap);
  assign n_cols       = ceil_div(32'(shp_w), 32'(N_BUF_X));
  assign total_words  = 64'(col_len_full) * 64'(n_cols);
  assign shape_zero   = (n_wrap == '0) || (shp_h == '0) || (shp_w == '0);
  assign shape_ovf    = total_words > (64'(1) << B_BUF_ADDR);

  assign start_acc = start && (state == WB_IDLE);
  assign s_tready  = (state == WB_WRITE);
  assign hs        = s_tvalid && s_tready;
  assign last_word = col_end && (x_idx == w_q - SHAPE_FIELD_W'(1));
  assign busy      = (state != WB_IDLE);
  assign done      = (state == WB_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WB_IDLE:  if (start) state_nxt = (shape_zero || shape_ovf) ? WB_DONE : WB_WRITE;
      WB_WRITE: if (hs && last_word) state_nxt = WB_DONE;
      WB_DONE:  state_nxt = WB_IDLE;
      default:  state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      col_len_q <= '0;
      err       <= 1'b0;
    end else if (start_acc) begin
      w_q       <= shp_w;
      col_len_q <= col_len_full[AW1-1:0];
      err       <= shape_ovf;
    end else if (hs && (s_tlast != last_word)) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wren   <= '0;
      wraddr <= '0;
      wrdata <= '0;
    end else begin
      wren   <= '0;
      wraddr <= '0;
      if (hs) begin
        wrdata <= s_tdata;
        for (int unsigned i = 0; i < N_BUF_X; i++) begin
          if (rx == RX_W'(i)) begin
            wren[i]                              <= 1'b1;
            wraddr[i*B_BUF_ADDR +: B_BUF_ADDR]   <= addr;
          end
        end
      end
    end
  end

  weight_addr_gen #(
    .N_BUF_X    (N_BUF_X),
    .B_BUF_ADDR (B_BUF_ADDR),
    .X_W        (SHAPE_FIELD_W),
    .RX_W       (RX_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_acc),
    .adv     (hs),
    .col_len (col_len_q),
    .addr    (addr),
    .rx      (rx),
    .x_idx   (x_idx),
    .col_end (col_end)
  );

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Randomized bench for weight_buffer_writer: expected bank/address/data
// sequences come from the tensor-order formula, not from counters.
module tb_weight_buffer_writer;

  localparam int unsigned N  = 5;
  localparam int unsigned B  = 9;
  localparam int unsigned SW = 48;
  localparam int unsigned DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SW-1:0]   wei_shape = '0;
  logic            start = 1'b0;
  logic [DW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tlast = 1'b0;
  logic            s_tready;
  logic [B*N-1:0]  wraddr;
  logic [DW-1:0]   wrdata;
  logic [N-1:0]    wren;
  logic            busy, done, err;

  weight_buffer_writer #(
    .N_BUF_X    (N),
    .B_BUF_ADDR (B),
    .B_SHAPE    (SW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wei_shape (wei_shape),
    .start     (start),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .wraddr    (wraddr),
    .wrdata    (wrdata),
    .wren      (wren),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write monitor: logs every write and flags writes without a handshake one cycle earlier.
  typedef struct {
    int unsigned bank;
    int unsigned addr;
    logic [63:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         wlog[$];
  int unsigned cyc_n = 0, done_n = 0, done_cyc = 0, rdy_n = 0, bad_wr_n = 0;

  initial begin
    logic        prev_hs;
    logic [63:0] prev_dat;
    wr_t         e;
    int unsigned nb;
    prev_hs  = 1'b0;
    prev_dat = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (wren != '0) begin
        nb = 0;
        e.bank = 0;
        for (int b = 0; b < N; b++) if (wren[b]) begin nb++; e.bank = b; end
        for (int b = 0; b < N; b++)
          if (!wren[b] && wraddr[b*B +: B] != '0) bad_wr_n++;
        if (nb != 1) bad_wr_n++;
        if (!prev_hs || wrdata !== prev_dat) bad_wr_n++;
        e.addr = wraddr[e.bank*B +: B];
        e.data = wrdata;
        e.cyc  = cyc_n;
        wlog.push_back(e);
      end
      if (done) begin done_n++; done_cyc = cyc_n; end
      if (s_tready) rdy_n++;
      prev_hs  = s_tvalid && s_tready && !rst;
      prev_dat = s_tdata;
    end
  end

  task automatic pulse_start(input int unsigned c, input int unsigned h, input int unsigned w);
    @(posedge clk); #1;
    wei_shape = {16'(w), 16'(h), 16'(c)};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream_words(input logic [63:0] dat[$], input int unsigned n, input int unsigned pct,
                              input int bad_idx, input int unsigned stop_at, output int unsigned sent);
    int unsigned cyc;
    logic        hs;
    cyc  = 0;
    sent = 0;
    while (sent < stop_at && cyc < 4000) begin
      s_tvalid = ($urandom_range(99) < pct);
      s_tdata  = dat[sent];
      s_tlast  = ((sent == n - 1) != (int'(sent) == bad_idx));
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic load_and_check(input string tag, input int unsigned c, input int unsigned h,
                                input int unsigned w, input int unsigned pct, input int bad_idx);
    int unsigned nw, ncol, n_exp, lb, db, rb, bb, sent, got_n;
    logic        zero, ovf, exp_err;
    logic [63:0] dat[$];
    int unsigned eb[$], ea[$];
    nw    = c >> 6;
    ncol  = (w + N - 1) / N;
    zero  = (nw == 0) || (h == 0) || (w == 0);
    ovf   = !zero && (h * nw * ncol > (1 << B));
    n_exp = (zero || ovf) ? 0 : w * h * nw;
    exp_err = ovf || (n_exp > 0 && bad_idx >= 0);
    for (int unsigned x = 0; x < w && n_exp > 0; x++)
      for (int unsigned y = 0; y < h; y++)
        for (int unsigned k = 0; k < nw; k++) begin
          eb.push_back(x % N);
          ea.push_back(nw * (y + h * (x / N)) + k);
          dat.push_back({$urandom, $urandom});
        end
    lb = wlog.size(); db = done_n; rb = rdy_n; bb = bad_wr_n;
    pulse_start(c, h, w);
    if (n_exp == 0) begin
      s_tvalid = 1'b1;
      @(negedge clk);
      check({tag, " done_next_cycle"}, done, 1);
      repeat (3) @(negedge clk);
      s_tvalid = 1'b0;
      check({tag, " tready_never"}, rdy_n - rb, 0);
    end else begin
      stream_words(dat, n_exp, pct, bad_idx, n_exp, sent);
      check({tag, " words_sent"}, sent, n_exp);
      repeat (4) @(negedge clk);
    end
    got_n = wlog.size() - lb;
    check({tag, " write_count"}, got_n, n_exp);
    for (int unsigned j = 0; j < n_exp && j < got_n; j++) begin
      check($sformatf("%s w%0d bank", tag, j), wlog[lb+j].bank, eb[j]);
      check($sformatf("%s w%0d addr", tag, j), wlog[lb+j].addr, ea[j]);
      check($sformatf("%s w%0d data", tag, j), wlog[lb+j].data, dat[j]);
    end
    check({tag, " done_once"}, done_n - db, 1);
    if (n_exp > 0 && got_n > 0)
      check({tag, " done_with_last_wr"}, done_cyc, wlog[wlog.size()-1].cyc);
    check({tag, " write_protocol"}, bad_wr_n - bb, 0);
    check({tag, " err"}, err, exp_err);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    int unsigned lb, db, sent;
    logic [63:0] dat[$];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst s_tready", s_tready, 0);
    check("rst wren", 64'(wren), 0);
    check("rst wraddr", 64'(wraddr), 0);
    check("rst wrdata", wrdata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);

    lb = wlog.size();
    load_and_check("base", 128, 3, 7, 100, -1);
    if (wlog.size() >= lb + 42) begin
      check("base w30 bank", wlog[lb+30].bank, 0);
      check("base w30 addr", wlog[lb+30].addr, 6);
      check("base w41 bank", wlog[lb+41].bank, 1);
      check("base w41 addr", wlog[lb+41].addr, 11);
    end else begin
      check("base log_len", wlog.size() - lb, 42);
    end

    load_and_check("bubbles", 128, 3, 7, 50, -1);
    load_and_check("nwrap0", 32, 3, 7, 100, -1);
    load_and_check("overflow", 128, 255, 10, 100, -1);
    load_and_check("bad_tlast", 128, 3, 7, 100, 5);

    // Abort mid-load: reset lands on the cycle word 20 is offered.
    for (int unsigned i = 0; i < 42; i++) dat.push_back({$urandom, $urandom});
    lb = wlog.size(); db = done_n;
    pulse_start(128, 3, 7);
    stream_words(dat, 42, 100, -1, 20, sent);
    check("abort sent", sent, 20);
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = dat[20];
    @(posedge clk); #1;
    check("abort wren", 64'(wren), 0);
    check("abort s_tready", s_tready, 0);
    check("abort busy", busy, 0);
    rst      = 1'b0;
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort writes", wlog.size() - lb, 20);
    check("abort no_done", done_n - db, 0);
    load_and_check("reload", 128, 3, 7, 100, -1);

    for (int t = 0; t < 4; t++)
      load_and_check($sformatf("rand%0d", t), 64 * $urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 12), $urandom_range(30, 100), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_buffer_writer.md
WEIGHT_BUFFER_WRITER -- requirements
Module: weight_buffer_writer

Interface
REQ-001 SHALL have parameter N_BUF_X, default 5, number of weight buffer banks (x-interleaved).
REQ-002 SHALL have parameter B_BUF_ADDR, default 9, per-bank address width.
REQ-003 SHALL have parameter B_SHAPE, default 48, shape bus width: c [15:0], h [31:16], w [47:32].
REQ-004 SHALL have parameter DATA_WIDTH, default 64, stream word and bank data width.
REQ-005 SHALL have port clk  in  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port wei_shape  in  B_SHAPE  weight tensor shape, sampled on accepted start.
REQ-008 SHALL have port start  in  1  one-cycle request to begin a load.
REQ-009 SHALL have port s_tdata  in  DATA_WIDTH  input stream word (from DDR reader).
REQ-010 SHALL have port s_tvalid  in  1  stream word valid.
REQ-011 SHALL have port s_tlast  in  1  marks final word of tensor.
REQ-012 SHALL have port s_tready  out  1  writer accepts word.
REQ-013 SHALL have port wraddr  out  B_BUF_ADDR*N_BUF_X  per-bank write address; bank i at [i*B_BUF_ADDR +: B_BUF_ADDR].
REQ-014 SHALL have port wrdata  out  DATA_WIDTH  write data, shared by all banks.
REQ-015 SHALL have port wren  out  N_BUF_X  per-bank write enable, at most one bit set.
REQ-016 SHALL have port busy  out  1  high outside IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse at load completion.
REQ-018 SHALL have port err  out  1  sticky error flag, cleared on next accepted start.

Function
REQ-019 SHALL implement states IDLE, WRITE, DONE; start accepted only in IDLE, ignored otherwise.
REQ-020 SHALL on accepted start latch c, h, w, compute n_wrap = c >> 6, col_len = h*n_wrap, and clear err.
REQ-021 SHALL go IDLE->DONE with no writes if n_wrap, h or w is zero.
REQ-022 SHALL go IDLE->DONE with err=1 and no writes if col_len*ceil(w/N_BUF_X) > 2^B_BUF_ADDR.
REQ-023 SHALL otherwise go IDLE->WRITE; s_tready=1 only in WRITE.
REQ-024 SHALL take stream order: channel chunk k innermost, then y, then x; word (x,y,k) goes to bank x mod N_BUF_X, address n_wrap*(y + h*floor(x/N_BUF_X)) + k.
REQ-025 SHALL generate addresses by counters only (column offset, bank index rx, bank base); no per-word multiplier.
REQ-026 SHALL per handshake (s_tvalid & s_tready) register a write: next cycle wren one-hot at rx, wraddr of that bank = base+offset, others 0, wrdata = s_tdata; latency exactly 1 cycle.
REQ-027 SHALL at column end (offset == col_len-1) reset offset, and if rx == N_BUF_X-1 set rx=0, base += col_len, else rx += 1.
REQ-028 SHALL hold all counters when s_tvalid=0 (no bubble penalty beyond the stall).
REQ-029 SHALL on final word (x=w-1, offset=col_len-1) go WRITE->DONE, dropping s_tready the next cycle.
REQ-030 SHALL set err if s_tlast=1 on a non-final word or s_tlast=0 on the final word; the load still counts words to completion.
REQ-031 SHALL in DONE assert done for one cycle (coincident with last wren if any) and return to IDLE.

Reset
REQ-032 SHALL on rst: state IDLE; s_tready, wren, wraddr, wrdata, busy, done, err all 0; counters 0.
REQ-033 SHALL on rst mid-load abandon it immediately with no further writes and no done pulse.

Structure
REQ-034 SHALL place state encoding, shape field offsets (16-bit c/h/w) and channel chunk shift (6) in a shared package also used by weight_buffer_reader.
REQ-035 SHALL be a single module; an optional sub-module weight_addr_gen (rx/offset/base counters) is permitted.

Verification
REQ-036 SHALL test c=128,h=3,w=7: 42 words; word 30 -> bank 0 addr 6, word 41 -> bank 1 addr 11; done once; err=0.
REQ-037 SHALL test same shape with s_tvalid random 50%: identical bank/addr/data sequence, wren only after handshakes.
REQ-038 SHALL test c=32 (n_wrap=0): done one cycle after start, no wren, s_tready never high.
REQ-039 SHALL test h=255,c=128,w=10: err=1, done pulse, no wren.
REQ-040 SHALL test s_tlast on word 5 of 42: err=1 after, load completes at word 42 with done.
REQ-041 SHALL test rst asserted at word 20: next cycle wren=0, s_tready=0, IDLE; new start reloads from bank 0 addr 0.
